// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses instruction memory
// and holds the fetched word in a valid/ready IF/ID slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e       state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] scnt_q, scnt_d;

    logic        fire;
    logic        hold;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign fire     = ~redirect_valid & ((state_q == EMPTY) | id_ready);
    assign hold     = ~redirect_valid & (state_q == FULL) & ~id_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            idpc_q  <= 32'd0;
            idpc4_q <= 32'd0;
            fcnt_q  <= 32'd0;
            scnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            fcnt_q  <= fcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = EMPTY;
        end else if (fire) begin
            state_d = FULL;
        end
    end

    // A redirect flushes the slot but leaves its stale contents in place.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        fcnt_d  = fcnt_q;
        scnt_d  = scnt_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[31:2], 2'b00};
        end else if (fire) begin
            instr_d = imem_rdata;
            idpc_d  = pc_q;
            idpc4_d = pc_plus4;
            pc_d    = pc_plus4;
            fcnt_d  = fcnt_q + 32'd1;
        end else if (hold) begin
            scnt_d  = scnt_q + 32'd1;
        end
    end

    always_comb begin
        imem_addr   = pc_q;
        id_valid    = (state_q == FULL);
        id_instr    = instr_q;
        id_pc       = idpc_q;
        id_pc4      = idpc4_q;
        fetch_count = fcnt_q;
        stall_count = scnt_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a
// transaction-level model of the PC and IF/ID slot.
module tb_fetch_stage;

    localparam logic [31:0] MASK = 32'hA5A5_0000;
    localparam logic [31:0] PC_A = 32'h0000_0100;
    localparam logic [31:0] PC_B = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0;
    logic        rdy_a = 1'b0;
    logic        redir_a = 1'b0;
    logic [31:0] tgt_a = 32'd0;
    logic        rd_rand = 1'b1;
    logic [31:0] rword = 32'd0;
    logic [31:0] addr_a, rdata_a, instr_a, idpc_a, pc4_a, fc_a, sc_a;
    logic        vld_a;

    logic        rst_b = 1'b0;
    logic        rdy_b = 1'b0;
    logic [31:0] addr_b, rdata_b, instr_b, idpc_b, pc4_b, fc_b, sc_b;
    logic        vld_b;

    assign rdata_a = rd_rand ? rword : (addr_a ^ MASK);
    assign rdata_b = addr_b ^ MASK;

    fetch_stage #(.RESET_PC(PC_A)) dut_a (
        .clk(clk), .reset(rst_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a),
        .id_valid(vld_a), .id_ready(rdy_a),
        .id_instr(instr_a), .id_pc(idpc_a), .id_pc4(pc4_a),
        .redirect_valid(redir_a), .redirect_target(tgt_a),
        .fetch_count(fc_a), .stall_count(sc_a)
    );

    fetch_stage #(.RESET_PC(PC_B)) dut_b (
        .clk(clk), .reset(rst_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b),
        .id_valid(vld_b), .id_ready(rdy_b),
        .id_instr(instr_b), .id_pc(idpc_b), .id_pc4(pc4_b),
        .redirect_valid(1'b0), .redirect_target(32'd0),
        .fetch_count(fc_b), .stall_count(sc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: PC, a one-entry slot queue, last slot contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      slot[$];
    entry_t      last = '0;
    logic [31:0] m_pc = PC_A;
    logic [31:0] m_fc = 32'd0;
    logic [31:0] m_sc = 32'd0;

    task automatic model_step();
        logic [31:0] word;
        word = rd_rand ? rword : (m_pc ^ MASK);
        if (!rst_a) begin
            slot.delete();
            last = '0;
            m_pc = PC_A;
            m_fc = 0;
            m_sc = 0;
        end else if (redir_a) begin
            slot.delete();
            m_pc = tgt_a & ~32'd3;
        end else if (slot.size() == 0 || rdy_a) begin
            if (slot.size() != 0) void'(slot.pop_front());
            last = '{instr: word, pc: m_pc};
            slot.push_back(last);
            m_pc = m_pc + 4;
            m_fc = m_fc + 1;
        end else begin
            m_sc = m_sc + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("imem_addr", addr_a, m_pc);
        check("id_valid", {31'd0, vld_a}, slot.size());
        check("id_instr", instr_a, last.instr);
        check("id_pc", idpc_a, last.pc);
        check("id_pc4", pc4_a, (last.pc == 0 && m_fc == 0) ? 32'd0
                                                           : last.pc + 4);
        check("fetch_count", fc_a, m_fc);
        check("stall_count", sc_a, m_sc);
    endtask

    logic [31:0] sc0, fc0;

    initial begin
        // Reset with random rdata and redirects.
        for (int i = 0; i < 3; i++) begin
            rst_a = 1'b0;
            rd_rand = 1'b1;
            rword = $urandom;
            redir_a = $urandom_range(0, 1);
            tgt_a = $urandom;
            rdy_a = $urandom_range(0, 1);
            tick();
        end
        check("rst_addr", addr_a, PC_A);
        check("rst_valid", {31'd0, vld_a}, 32'd0);

        // Streaming.
        rst_a = 1'b1; redir_a = 1'b0; rdy_a = 1'b1; rd_rand = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_pc", idpc_a, PC_A + 32'(4 * i));
            check("stream_instr", instr_a, (PC_A + 32'(4 * i)) ^ MASK);
        end

        // Backpressure at id_pc=0x108.
        rst_a = 1'b0; tick();
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("bp_pc", idpc_a, 32'h108);
        sc0 = sc_a; fc0 = fc_a;
        rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_pc", idpc_a, 32'h108);
            check("bp_addr", addr_a, 32'h10C);
        end
        check("bp_stalls", sc_a, sc0 + 4);
        check("bp_fetch", fc_a, fc0);
        rdy_a = 1'b1; tick();
        check("bp_release", idpc_a, 32'h10C);

        // Redirect while FULL and ready.
        fc0 = fc_a;
        redir_a = 1'b1; tgt_a = 32'h2003; tick();
        check("rd_valid", {31'd0, vld_a}, 32'd0);
        check("rd_addr", addr_a, 32'h2000);
        check("rd_fetch", fc_a, fc0);
        redir_a = 1'b0; tick();
        check("rd_target", idpc_a, 32'h2000);

        // Reset while FULL, stalled and redirecting.
        rdy_a = 1'b0; tick();
        rst_a = 1'b0; redir_a = 1'b1; tgt_a = 32'h4000; tick();
        check("mid_valid", {31'd0, vld_a}, 32'd0);
        check("mid_addr", addr_a, PC_A);
        rst_a = 1'b1; redir_a = 1'b0; rdy_a = 1'b1; tick();
        check("mid_next", idpc_a, PC_A);

        // Wrap on the second instance.
        rst_b = 1'b1; rdy_b = 1'b1;
        tick();
        check("wrap_pc0", idpc_b, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", idpc_b, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_b, 32'h0000_0000);
        check("wrap_instr", instr_b, 32'hFFFF_FFFC ^ MASK);
        tick();
        check("wrap_pc2", idpc_b, 32'h0000_0000);
        check("wrap_cnt", fc_b, 32'd3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_a   = ($urandom_range(0, 99) >= 2);
            rdy_a   = ($urandom_range(0, 99) < 70);
            redir_a = ($urandom_range(0, 99) < 10);
            tgt_a   = $urandom;
            rd_rand = $urandom_range(0, 1);
            rword   = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
